// File: rtl/imem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_access_ctrl
// Description : Round-robin sequencer sharing a single-port instruction memory
//               between IF-stage fetches and loader writes, with fetch flush.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_access_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              flush,
    input  logic              ld_req,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_gnt,
    output logic              ld_done,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic       SRC_FETCH = 1'b0;
    localparam logic       SRC_LOAD  = 1'b1;
    localparam logic [3:0] LAST_CNT  = 4'(MEM_LAT - 1);

    state_t state;
    state_t state_next;

    logic [3:0]        cnt;
    logic              kill;
    logic              last_grant;
    logic              rd_err;
    logic [ADDR_W-1:0] if_word;
    logic [ADDR_W-1:0] ld_word;
    logic              if_bad;
    logic              ld_bad;
    logic              read_last;

    assign if_word   = if_addr[ADDR_W+1:2];
    assign ld_word   = ld_addr[ADDR_W+1:2];
    assign if_bad    = (|if_addr[1:0]) | (|if_addr[31:ADDR_W+2]);
    assign ld_bad    = (|ld_addr[1:0]) | (|ld_addr[31:ADDR_W+2]);
    assign read_last = (state == READ) && (cnt == LAST_CNT);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        state_next = state;
        if_gnt     = 1'b0;
        ld_gnt     = 1'b0;
        case (state)
            IDLE: begin
                if (ld_req && (!if_req || (last_grant == SRC_FETCH))) begin
                    ld_gnt     = 1'b1;
                    state_next = WRITE;
                end else if (if_req) begin
                    if_gnt     = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                if (read_last) begin
                    state_next = IDLE;
                end
            end
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= 4'd0;
            kill       <= 1'b0;
            last_grant <= SRC_FETCH;
            rd_err     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= 32'd0;
            if_err     <= 1'b0;
            ld_done    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
        end else begin
            if_rvalid <= 1'b0;
            ld_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_gnt) begin
                        cnt        <= 4'd0;
                        kill       <= 1'b0;
                        rd_err     <= if_bad;
                        last_grant <= SRC_FETCH;
                        mem_en     <= !if_bad;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_word;
                    end else if (ld_gnt) begin
                        last_grant <= SRC_LOAD;
                        mem_en     <= !ld_bad;
                        mem_we     <= !ld_bad;
                        mem_addr   <= ld_word;
                        mem_wdata  <= ld_wdata;
                        ld_done    <= 1'b1;
                    end
                end
                READ: begin
                    if (flush) begin
                        kill <= 1'b1;
                    end
                    if (cnt == LAST_CNT) begin
                        mem_en <= 1'b0;
                        // A flush in the final read cycle still suppresses delivery.
                        if (!kill && !flush) begin
                            if_rvalid <= 1'b1;
                            if_err    <= rd_err;
                            if_rdata  <= rd_err ? 32'd0 : mem_rdata;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                WRITE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_access_ctrl
// Description : Scoreboard bench for imem_access_ctrl with a behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_access_ctrl;

    localparam int ADDR_W  = 10;
    localparam int MEM_LAT = 2;

    logic              clk;
    logic              reset;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              if_err;
    logic              flush;
    logic              ld_req;
    logic [31:0]       ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_gnt;
    logic              ld_done;
    logic              busy;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    imem_access_ctrl #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .flush(flush),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_done(ld_done), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } rd_exp_t;

    typedef struct {
        int          due;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } ld_exp_t;

    rd_exp_t     rd_q[$];
    ld_exp_t     ld_q[$];
    rd_exp_t     rd_e;
    ld_exp_t     ld_e;
    logic [31:0] mem[int];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          gnt_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] def_word(input logic [9:0] a);
        return 32'h1000_0000 | {22'h0, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural memory: read data presented while enabled, unwritten words read a pattern
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[int'(mem_addr)] = mem_wdata;
    end
    always @(negedge clk) begin
        if (!mem_en)                      mem_rdata = 32'h0;
        else if (mem.exists(int'(mem_addr))) mem_rdata = mem[int'(mem_addr)];
        else                              mem_rdata = def_word(mem_addr);
    end

    always @(negedge clk) begin
        if (reset) begin
            check("gnt_excl", {31'b0, if_gnt & ld_gnt}, 32'd0);
            if (if_rvalid) begin
                if (rd_q.size() == 0) begin
                    check("rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    rd_e = rd_q.pop_front();
                    check("rvalid_cycle", 32'(cyc), 32'(rd_e.due));
                    check("if_rdata", if_rdata, rd_e.data);
                    check("if_err", {31'b0, if_err}, {31'b0, rd_e.err});
                end
            end
            if (ld_done) begin
                if (ld_q.size() == 0) begin
                    check("ld_done_unexpected", 32'd1, 32'd0);
                end else begin
                    ld_e = ld_q.pop_front();
                    check("ld_done_cycle", 32'(cyc), 32'(ld_e.due));
                    check("ld_mem_we", {31'b0, mem_we}, {31'b0, ld_e.we});
                    check("ld_mem_en", {31'b0, mem_en}, {31'b0, ld_e.we});
                    if (ld_e.we) begin
                        check("ld_mem_addr", {22'b0, mem_addr}, {22'b0, ld_e.addr});
                        check("ld_mem_wdata", mem_wdata, ld_e.wdata);
                    end
                end
            end
        end
    end

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input logic e,
                            input logic flush_t1, input logic flush_gnt);
        int n = 0;
        @(negedge clk);
        if_req = 1'b1;
        if_addr = a;
        #1;
        while (!if_gnt && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!if_gnt) begin
            check("fetch_gnt_timeout", 32'd0, 32'd1);
            if_req = 1'b0;
            return;
        end
        gnt_cyc = cyc;
        if (!flush_t1) rd_q.push_back('{cyc + MEM_LAT + 1, e ? 32'h0 : d, e});
        flush = flush_gnt;
        @(posedge clk);
        #1;
        if_req = 1'b0;
        flush  = 1'b0;
        @(negedge clk);
        check("rd_mem_en", {31'b0, mem_en}, {31'b0, !e});
        check("rd_busy", {31'b0, busy}, 32'd1);
        if (!e) check("rd_mem_addr", {22'b0, mem_addr}, {22'b0, a[11:2]});
        if (flush_t1) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] wd, input logic bad);
        int n = 0;
        @(negedge clk);
        ld_req   = 1'b1;
        ld_addr  = a;
        ld_wdata = wd;
        #1;
        while (!ld_gnt && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!ld_gnt) begin
            check("load_gnt_timeout", 32'd0, 32'd1);
            ld_req = 1'b0;
            return;
        end
        ld_q.push_back('{cyc + 1, !bad, a[11:2], wd});
        @(posedge clk);
        #1;
        ld_req = 1'b0;
    endtask

    initial begin
        int g0;
        int k;
        int n;
        logic exp_ld;
        reset = 1'b0; if_req = 1'b0; if_addr = 32'h0; flush = 1'b0;
        ld_req = 1'b0; ld_addr = 32'h0; ld_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
        check("rst_ld_done", {31'b0, ld_done}, 32'd0);
        check("rst_mem_en", {31'b0, mem_en}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b1;

        do_load(32'h8, 32'h0050_0093, 1'b0);
        do_fetch(32'h8, 32'h0050_0093, 1'b0, 1'b0, 1'b0);

        do_fetch(32'h0, def_word(10'd0), 1'b0, 1'b0, 1'b0);
        g0 = gnt_cyc;
        do_fetch(32'h4, def_word(10'd1), 1'b0, 1'b0, 1'b0);
        check("b2b_gap", 32'(gnt_cyc - g0), 32'd3);

        do_fetch(32'h2, 32'h0, 1'b1, 1'b0, 1'b0);
        do_fetch(32'h0000_1000, 32'h0, 1'b1, 1'b0, 1'b0);
        do_load(32'h0000_1000, 32'hDEAD_0001, 1'b1);

        do_fetch(32'h8, 32'h0, 1'b0, 1'b1, 1'b0);
        g0 = gnt_cyc;
        do_fetch(32'h8, 32'h0050_0093, 1'b0, 1'b0, 1'b0);
        check("flush_regrant", 32'(gnt_cyc - g0), 32'd3);
        do_fetch(32'h8, 32'h0050_0093, 1'b0, 1'b0, 1'b1);

        repeat (4) @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        ld_req = 1'b1; ld_addr = 32'h10; ld_wdata = 32'hCAFE_0004;
        #1;
        exp_ld = 1'b1; k = 0; n = 0;
        while (k < 6 && n < 60) begin
            if (if_gnt || ld_gnt) begin
                check("arb_order", {31'b0, ld_gnt}, {31'b0, exp_ld});
                if (ld_gnt) ld_q.push_back('{cyc + 1, 1'b1, 10'h4, 32'hCAFE_0004});
                else        rd_q.push_back('{cyc + MEM_LAT + 1, 32'hCAFE_0004, 1'b0});
                exp_ld = !exp_ld;
                k++;
            end
            @(negedge clk);
            #1;
            n++;
        end
        check("arb_grants", 32'(k), 32'd6);
        if_req = 1'b0; ld_req = 1'b0;

        repeat (5) @(negedge clk);
        if_req = 1'b1; if_addr = 32'hC;
        #1;
        n = 0;
        while (!if_gnt && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rstmid_gnt", {31'b0, if_gnt}, 32'd1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstmid_mem_en", {31'b0, mem_en}, 32'd0);
        check("rstmid_busy", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        if_req = 1'b1; if_addr = 32'h20;
        ld_req = 1'b1; ld_addr = 32'h20; ld_wdata = 32'h1234_5678;
        #1;
        check("rst_tie_ld_gnt", {31'b0, ld_gnt}, 32'd1);
        check("rst_tie_if_gnt", {31'b0, if_gnt}, 32'd0);
        if (ld_gnt) ld_q.push_back('{cyc + 1, 1'b1, 10'h8, 32'h1234_5678});
        @(posedge clk);
        #1;
        if_req = 1'b0; ld_req = 1'b0;

        repeat (10) @(negedge clk);
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);
        check("ld_q_empty", 32'(ld_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
